ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the single-port synchronous RAM: the RAM port (chip select, read enable, write enable, address, data in, registered data out) is fed from a client-side burst command interface.
- Accepts one command at a time: start address, length, direction.
- Writes consume a valid/ready input stream; reads produce a valid/ready output stream, with backpressure absorbed despite the RAM's 1-cycle read latency.

Parameters:
- add_size, 10, RAM address width; addresses wrap modulo 2^add_size.
- word_size, 8, RAM data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  add_size  start address.
- cmd_len  in  add_size  burst length minus one (0 = 1 word, max 2^add_size words).
- wr_data  in  word_size  write beat data.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready.
- rd_data  out  word_size  read beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  client accepts read beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at burst completion.
- ram_cs  out  1  RAM chip select; equals ram_we | ram_re.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  add_size  RAM address.
- ram_din  out  word_size  RAM write data.
- ram_dout  in  word_size  RAM registered read data; valid the cycle after the edge that sampled ram_re.

Behaviour:
- States: IDLE, WRITE, READ, DONE.
- Reset (rst high at an edge): state IDLE, counters 0, read FIFO emptied, in-flight flag cleared. After that edge every output is 0 except cmd_ready = 1. While rst is high, ram_we, ram_re and ram_cs are forced 0 combinationally.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr, len and direction; go to WRITE or READ at that edge.
- WRITE:
  - wr_ready = 1.
  - Each cycle with wr_valid = 1: ram_we = ram_cs = 1, ram_addr = current address, ram_din = wr_data (combinational pass-through). The RAM writes at that edge.
  - Address increments with wrap; remaining count decrements.
  - Accepting beat len+1 moves to DONE.
  - wr_valid low: no strobe, no progress.
- READ:
  - 2-entry output FIFO plus a 1-bit in-flight flag.
  - Issue ram_re = ram_cs = 1 at the current address when words remain to issue and (fifo_count + in_flight - pop) < 2, where pop = rd_valid & rd_ready this cycle.
  - An issue at edge N sets in_flight. ram_dout is pushed into the FIFO at edge N+1, with in_flight cleared unless a new read was issued at N+1.
  - rd_valid = FIFO non-empty; rd_data = FIFO head.
  - Full throughput with rd_ready held high: one word per cycle after 2-cycle latency.
  - Command accepted at edge E: first ram_re in cycle E+1, first rd_valid in cycle E+3.
  - All words issued, none in flight, FIFO empty and final pop done moves to DONE.
- DONE: done = 1 for exactly one cycle, busy = 1, then IDLE.
- Invariants:
  - ram_we and ram_re are never both 1.
  - No strobes in IDLE or DONE.
  - rd_valid only in READ; wr_ready only in WRITE.
  - Held rd_data stays stable while rd_valid & !rd_ready.
- Wrap: address 2^add_size-1 is followed by 0. A burst of 2^add_size words touches every location once.
- Commands offered while busy are not accepted (cmd_ready = 0); no latching.
- Reset mid-burst: the burst is abandoned; no done pulse; FIFO data is discarded.

Test Plan:
- Write burst cmd_addr=0x3FE, cmd_len=3, data A1,B2,C3,D4 with wr_valid constant -> ram_we on 4 consecutive cycles at addresses 0x3FE,0x3FF,0x000,0x001; done pulse the cycle after the last beat.
- Read burst same address/len, rd_ready=1 -> rd_data A1,B2,C3,D4 on 4 consecutive cycles starting 3 cycles after command accept; ram_re never with ram_we.
- Same read with rd_ready toggling 1,0,0,1,... -> no lost or duplicated words; rd_data stable while stalled; ram_re issues never exceed 2 outstanding.
- cmd_len=0 write of 0x5A to 0x010, then read -> exactly one strobe each; rd_data=0x5A; busy back to 0 in the cycle after the done pulse.
- Reset asserted during 2nd beat of a 16-word read -> cycle after reset edge: rd_valid=0, busy=0, cmd_ready=1, no done; the next command works normally.
- cmd_valid held high during a write burst with different parameters -> ignored until IDLE; accepted on the first IDLE cycle.

Source files
------------

// File: rtl/ram_burst_master_if.sv
// Client-side burst command/stream handshakes and the single-port RAM strobes.
// The master modport is the burst engine; slave is its environment (client + RAM).
interface ram_burst_master_if #(
    parameter int add_size  = 10,
    parameter int word_size = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [add_size-1:0]  cmd_addr;
    logic [add_size-1:0]  cmd_len;
    logic [word_size-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [word_size-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic                 busy;
    logic                 done;
    logic                 ram_cs;
    logic                 ram_we;
    logic                 ram_re;
    logic [add_size-1:0]  ram_addr;
    logic [word_size-1:0] ram_din;
    logic [word_size-1:0] ram_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready, ram_dout,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        output ram_cs, ram_we, ram_re, ram_addr, ram_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready, ram_dout,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        input  ram_cs, ram_we, ram_re, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle registered read data.
// Reads go through a 2-entry skid FIFO so client backpressure never drops an in-flight word.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WRITE | one RAM write per accepted wr beat
// READ  | issuing reads and draining the output FIFO
// DONE  | one-cycle completion pulse
module ram_burst_master #(
    parameter int add_size  = 10,
    parameter int word_size = 8
) (
    input logic               clk,
    input logic               rst,
    ram_burst_master_if.master bus
);
    localparam int cnt_w = add_size + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t               state_q, state_d;
    logic [add_size-1:0]  addr_q, addr_d;
    logic [cnt_w-1:0]     left_q, left_d;
    logic                 in_flight_q, in_flight_d;
    logic [word_size-1:0] fifo_q [2];
    logic                 head_q;
    logic [1:0]           cnt_q;

    logic       we, issue, wr_rdy, pop, push, tail;
    logic [2:0] occ;

    assign pop  = (cnt_q != 2'd0) && bus.rd_ready;
    assign push = in_flight_q;
    assign tail = head_q ^ cnt_q[0];
    // Slots that will be occupied once everything already requested has landed.
    assign occ  = {1'b0, cnt_q} + {2'b00, in_flight_q} - {2'b00, pop};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        in_flight_d = 1'b0;
        we          = 1'b0;
        issue       = 1'b0;
        wr_rdy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    left_d  = {1'b0, bus.cmd_len} + cnt_w'(1);
                    state_d = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_rdy = 1'b1;
                if (bus.wr_valid) begin
                    we     = 1'b1;
                    addr_d = addr_q + add_size'(1);
                    left_d = left_q - cnt_w'(1);
                    if (left_q == cnt_w'(1)) state_d = DONE;
                end
            end
            READ: begin
                if ((left_q != '0) && (occ < 3'd2)) begin
                    issue  = 1'b1;
                    addr_d = addr_q + add_size'(1);
                    left_d = left_q - cnt_w'(1);
                end
                in_flight_d = issue;
                if ((left_q == '0) && !in_flight_q &&
                    ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            in_flight_q <= 1'b0;
            head_q      <= 1'b0;
            cnt_q       <= 2'd0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            in_flight_q <= in_flight_d;
            if (push) fifo_q[tail] <= bus.ram_dout;
            head_q      <= head_q ^ pop;
            cnt_q       <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.ram_we    = we & ~rst;
    assign bus.ram_re    = issue & ~rst;
    assign bus.ram_cs    = bus.ram_we | bus.ram_re;
    assign bus.ram_addr  = (we | issue) ? addr_q : '0;
    assign bus.ram_din   = we ? bus.wr_data : '0;
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.wr_ready  = wr_rdy;
    assign bus.rd_valid  = (cnt_q != 2'd0);
    assign bus.rd_data   = fifo_q[head_q];
endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: behavioural RAM, expected-data scoreboard,
// write/read bursts with wrap, backpressure, single-word, busy command hold and mid-burst reset.
module tb_ram_burst_master;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_burst_master_if #(.add_size(AW), .word_size(DW)) bus ();
    ram_burst_master #(.add_size(AW), .word_size(DW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    logic [DW-1:0] ram_mem [1<<AW];
    logic [DW-1:0] exp_mem [1<<AW];
    logic [DW-1:0] wbuf [16];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] exp_a [$];
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        if (bus.ram_cs && bus.ram_re) bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int gap,
                               input bit hold, input logic [AW-1:0] haddr, input logic [AW-1:0] hlen);
        logic [AW-1:0] a;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        a = addr;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = addr; bus.cmd_len = len;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready: got %b expected 1", bus.cmd_ready); end
        @(posedge clk); #1;
        if (hold) begin
            bus.cmd_write = 1'b0; bus.cmd_addr = haddr; bus.cmd_len = hlen;
        end else bus.cmd_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == gap) begin
                bus.wr_valid = 1'b0;
                @(negedge clk);
                n_checks++;
                if (bus.ram_cs !== 1'b0 || bus.done !== 1'b0 || bus.wr_ready !== 1'b1) begin
                    n_fail++; $display("FAIL wr_gap: cs=%b done=%b wr_ready=%b expected 0 0 1", bus.ram_cs, bus.done, bus.wr_ready);
                end
                @(posedge clk); #1;
            end
            bus.wr_valid = 1'b1; bus.wr_data = wbuf[i];
            exp_mem[a] = wbuf[i];
            exp_q.push_back(wbuf[i]); exp_a.push_back(a);
            a = a + AW'(1);
            @(negedge clk);
            ea = exp_a.pop_front(); ed = exp_q.pop_front();
            n_checks++;
            if (bus.ram_we !== 1'b1 || bus.ram_cs !== 1'b1 || bus.ram_re !== 1'b0) begin
                n_fail++; $display("FAIL wr_strobe beat %0d: we=%b cs=%b re=%b expected 1 1 0", i, bus.ram_we, bus.ram_cs, bus.ram_re);
            end
            n_checks++;
            if (bus.ram_addr !== ea) begin n_fail++; $display("FAIL wr_addr beat %0d: got %h expected %h", i, bus.ram_addr, ea); end
            n_checks++;
            if (bus.ram_din !== ed) begin n_fail++; $display("FAIL wr_din beat %0d: got %h expected %h", i, bus.ram_din, ed); end
            if (hold) begin
                n_checks++;
                if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_cmd_ready beat %0d: got %b expected 0", i, bus.cmd_ready); end
            end
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.ram_cs !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: done=%b busy=%b cs=%b expected 1 1 0", bus.done, bus.busy, bus.ram_cs);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_idle: busy=%b done=%b cmd_ready=%b expected 0 0 1", bus.busy, bus.done, bus.cmd_ready);
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input bit stall, input bit skip_cmd);
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic [DW-1:0] held_d;
        bit pop, held, done_seen;
        int k, issued, popped, first_vk, first_pk, last_pk, done_k;
        a = addr; held = 0; done_seen = 0; held_d = '0;
        k = 0; issued = 0; popped = 0; first_vk = -1; first_pk = -1; last_pk = -1; done_k = -1;
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(exp_mem[addr + AW'(i)]);
        if (!skip_cmd) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = addr; bus.cmd_len = len;
            @(negedge clk);
            n_checks++;
            if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_ready: got %b expected 1", bus.cmd_ready); end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        while (!done_seen && k < 200) begin
            bus.rd_ready = stall ? (k % 3 == 0) : 1'b1;
            @(negedge clk);
            pop = bus.rd_valid && bus.rd_ready;
            n_checks++;
            if (bus.ram_we === 1'b1) begin n_fail++; $display("FAIL rd_no_we k=%0d: got we=%b expected 0", k, bus.ram_we); end
            if (held) begin
                n_checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== held_d) begin
                    n_fail++; $display("FAIL rd_hold k=%0d: valid=%b data=%h expected 1 %h", k, bus.rd_valid, bus.rd_data, held_d);
                end
            end
            if (bus.rd_valid && first_vk < 0) first_vk = k;
            if (bus.ram_re) begin
                n_checks++;
                if (bus.ram_addr !== a || bus.ram_cs !== 1'b1) begin
                    n_fail++; $display("FAIL rd_issue k=%0d: addr=%h cs=%b expected %h 1", k, bus.ram_addr, bus.ram_cs, a);
                end
                n_checks++;
                if ((issued + 1) - (popped + (pop ? 1 : 0)) > 2) begin
                    n_fail++; $display("FAIL rd_outstanding k=%0d: got %0d expected <=2", k, (issued + 1) - (popped + (pop ? 1 : 0)));
                end
                a = a + AW'(1);
                issued++;
            end
            if (pop) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_extra k=%0d: got beat %h expected none", k, bus.rd_data);
                end else begin
                    ed = exp_q.pop_front();
                    if (bus.rd_data !== ed) begin n_fail++; $display("FAIL rd_data beat %0d: got %h expected %h", popped, bus.rd_data, ed); end
                end
                if (first_pk < 0) first_pk = k;
                last_pk = k;
                popped++;
            end
            held   = bus.rd_valid && !bus.rd_ready;
            held_d = bus.rd_data;
            if (bus.done) begin done_seen = 1; done_k = k; end
            @(posedge clk); #1;
            k++;
        end
        bus.rd_ready = 1'b0;
        n_checks++;
        if (!done_seen) begin n_fail++; $display("FAIL rd_timeout: done seen %0d expected 1", done_seen); end
        n_checks++;
        if (popped != int'(len) + 1 || issued != int'(len) + 1) begin
            n_fail++; $display("FAIL rd_counts: popped=%0d issued=%0d expected %0d", popped, issued, int'(len) + 1);
        end
        n_checks++;
        if (first_vk != 2) begin n_fail++; $display("FAIL rd_latency: first rd_valid at %0d expected 2", first_vk); end
        n_checks++;
        if (done_k != last_pk + 1) begin n_fail++; $display("FAIL rd_done_time: got %0d expected %0d", done_k, last_pk + 1); end
        if (!stall) begin
            n_checks++;
            if (last_pk - first_pk != int'(len)) begin
                n_fail++; $display("FAIL rd_throughput: span %0d expected %0d", last_pk - first_pk, int'(len));
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rd_idle: busy=%b valid=%b done=%b expected 0 0 0", bus.busy, bus.rd_valid, bus.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0 ||
            bus.wr_ready !== 1'b0 || bus.ram_cs !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0 ||
            bus.ram_addr !== '0 || bus.ram_din !== '0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b busy=%b done=%b rv=%b wr=%b cs=%b we=%b re=%b addr=%h din=%h rd=%h expected only cmd_ready=1",
                     bus.cmd_ready, bus.busy, bus.done, bus.rd_valid, bus.wr_ready, bus.ram_cs, bus.ram_we,
                     bus.ram_re, bus.ram_addr, bus.ram_din, bus.rd_data);
        end
    endtask

    task automatic test_write_wrap();
        wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3; wbuf[3] = 8'hD4;
        write_burst(10'h3FE, 10'd3, -1, 0, '0, '0);
    endtask

    task automatic test_read_full();
        read_burst(10'h3FE, 10'd3, 0, 0);
    endtask

    task automatic test_read_stall();
        read_burst(10'h3FE, 10'd3, 1, 0);
    endtask

    task automatic test_single();
        wbuf[0] = 8'h5A;
        write_burst(10'h010, 10'd0, 0, 0, '0, '0);
        read_burst(10'h010, 10'd0, 0, 0);
    endtask

    task automatic test_cmd_while_busy();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        write_burst(10'h200, 10'd2, -1, 1, 10'h3FE, 10'd3);
        read_burst(10'h3FE, 10'd3, 0, 1);
    endtask

    task automatic test_reset_mid();
        int popped, guard;
        logic [DW-1:0] ed;
        for (int i = 0; i < 16; i++) wbuf[i] = DW'(i * 7 + 3);
        write_burst(10'h020, 10'd15, -1, 0, '0, '0);
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_mem[10'h020 + AW'(i)]);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 10'h020; bus.cmd_len = 10'd15;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.rd_ready = 1'b1;
        popped = 0; guard = 0;
        while (popped < 2 && guard < 20) begin
            @(negedge clk);
            if (bus.rd_valid && bus.rd_ready) begin
                ed = exp_q.pop_front();
                n_checks++;
                if (bus.rd_data !== ed) begin n_fail++; $display("FAIL mid_data beat %0d: got %h expected %h", popped, bus.rd_data, ed); end
                popped++;
            end
            guard++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (popped != 2) begin n_fail++; $display("FAIL mid_timeout: popped %0d expected 2", popped); end
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ram_cs !== 1'b0 || bus.ram_re !== 1'b0) begin
            n_fail++; $display("FAIL mid_strobe_gate: cs=%b re=%b expected 0 0", bus.ram_cs, bus.ram_re);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.rd_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL mid_after_reset: rv=%b busy=%b rdy=%b done=%b expected 0 0 1 0", bus.rd_valid, bus.busy, bus.cmd_ready, bus.done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ram_cs !== 1'b0) begin
                n_fail++; $display("FAIL mid_quiet cycle %0d: done=%b busy=%b cs=%b expected 0 0 0", i, bus.done, bus.busy, bus.ram_cs);
            end
        end
        read_burst(10'h3FE, 10'd3, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        test_reset();
        test_write_wrap();
        test_read_full();
        test_read_stall();
        test_single();
        test_cmd_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
